// File: rtl/offset_gen_pipe.sv
// offset_gen_pipe: multi-lane, two-stage offset generator for the unary PE modes.
// Stage 1 captures each lane's leading-one position and zero flag. Stage 2 turns
// them into a signed accumulator offset through a runtime-programmable log table.
// Lanes share one mode, one valid/ready handshake and one table.
module offset_gen_pipe #(
  parameter int  MUL_BW = 16,
  parameter int  ACC_BW = 32,
  parameter int  LANES  = 4,
  localparam int IDX_BW = $clog2(MUL_BW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode_i,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*MUL_BW-1:0] x_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACC_BW-1:0] offset_o,
  output logic [LANES-1:0]        zero_o,
  input  logic                    cfg_we,
  input  logic [IDX_BW-1:0]       cfg_addr,
  input  logic [ACC_BW-1:0]       cfg_data
);

  typedef enum logic [1:0] {
    MODE_GEMM = 2'b00,
    MODE_DIV  = 2'b01,
    MODE_EXP  = 2'b10,
    MODE_LOG  = 2'b11
  } mode_e;

  // A zero operand has no logarithm; it maps to the most negative offset.
  localparam logic [ACC_BW-1:0] MOST_NEG = {1'b1, {(ACC_BW-1){1'b0}}};

  logic [ACC_BW-1:0]       table_q [MUL_BW];

  logic                    s1Valid_q, s1Valid_d;
  mode_e                   s1Mode_q;
  logic [IDX_BW-1:0]       s1Idx_q [LANES];
  logic [IDX_BW-1:0]       s1Idx_d [LANES];
  logic [LANES-1:0]        s1Zero_q, s1Zero_d;

  logic                    outValid_q, outValid_d;
  logic [LANES*ACC_BW-1:0] offset_q, offset_d;
  logic [LANES-1:0]        zero_q, zero_d;

  logic                    s2Adv, s1Adv, accept, tableWe;

  // Backpressure flows from out_ready alone; in_valid never feeds in_ready.
  assign s2Adv    = !outValid_q || out_ready;
  assign s1Adv    = s1Valid_q && s2Adv;
  assign in_ready = !s1Valid_q || s1Adv;
  assign accept   = in_valid && in_ready;

  // Addresses past the last table entry can exist when MUL_BW is not a power of two.
  assign tableWe  = cfg_we && (int'(cfg_addr) < MUL_BW);

  assign out_valid = outValid_q;
  assign offset_o  = offset_q;
  assign zero_o    = zero_q;

  // Per lane: position of the most significant set bit, and whether the operand is zero.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      s1Idx_d[k]  = '0;
      s1Zero_d[k] = (x_i[k*MUL_BW +: MUL_BW] == '0);
      for (int b = 0; b < MUL_BW; b++) begin
        if (x_i[k*MUL_BW + b]) begin
          s1Idx_d[k] = IDX_BW'(b);
        end
      end
    end
  end

  // S1 stays full while it holds a beat that S2 cannot take yet.
  always_comb begin
    s1Valid_d = accept || (s1Valid_q && !s1Adv);
  end

  // Stage 1 registers: capture the decoded operand whenever a beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Mode_q  <= MODE_GEMM;
      s1Zero_q  <= '0;
      for (int k = 0; k < LANES; k++) begin
        s1Idx_q[k] <= '0;
      end
    end else begin
      s1Valid_q <= s1Valid_d;
      if (accept) begin
        s1Mode_q <= mode_e'(mode_i);
        s1Zero_q <= s1Zero_d;
        for (int k = 0; k < LANES; k++) begin
          s1Idx_q[k] <= s1Idx_d[k];
        end
      end
    end
  end

  // Stage 2 next state: the table is read as the beat moves out of S1, so a write on the same edge is not yet visible.
  always_comb begin
    outValid_d = outValid_q;
    offset_d   = offset_q;
    zero_d     = zero_q;
    if (s2Adv) begin
      outValid_d = s1Valid_q;
      if (s1Valid_q) begin
        for (int k = 0; k < LANES; k++) begin
          offset_d[k*ACC_BW +: ACC_BW] = '0;
          zero_d[k]                    = 1'b0;
          if (s1Mode_q == MODE_LOG) begin
            if (s1Zero_q[k]) begin
              offset_d[k*ACC_BW +: ACC_BW] = MOST_NEG;
              zero_d[k]                    = 1'b1;
            end else begin
              offset_d[k*ACC_BW +: ACC_BW] = table_q[s1Idx_q[k]];
            end
          end
        end
      end
    end
  end

  // Stage 2 registers: the outputs hold while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      offset_q   <= '0;
      zero_q     <= '0;
    end else begin
      outValid_q <= outValid_d;
      offset_q   <= offset_d;
      zero_q     <= zero_d;
    end
  end

  // Log offset table: written at any time, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_BW; i++) begin
        table_q[i] <= '0;
      end
    end else if (tableWe) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_offset_gen_pipe.sv
// tb_offset_gen_pipe: self-checking bench for offset_gen_pipe.
// Expected offsets come from a behavioural model (log2 by repeated halving plus
// a copy of the table) and a queue scoreboard that enforces order and no loss.
module tb_offset_gen_pipe;

  logic         clk = 1'b0;
  logic         rst_n;

  logic [1:0]   mode_i;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  x_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] offset_o;
  logic [3:0]   zero_o;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [31:0]  cfg_data;

  logic [1:0]   mode12;
  logic         inValid12;
  logic         inReady12;
  logic [11:0]  x12;
  logic         outValid12;
  logic         outReady12;
  logic [31:0]  offset12;
  logic [0:0]   zero12;
  logic         cfgWe12;
  logic [3:0]   cfgAddr12;
  logic [31:0]  cfgData12;

  logic [31:0]  mdlTable [16];
  logic [131:0] expQ [$];
  int           checks = 0;
  int           errors = 0;

  offset_gen_pipe dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .in_valid(in_valid), .in_ready(in_ready),
    .x_i(x_i), .out_valid(out_valid), .out_ready(out_ready), .offset_o(offset_o),
    .zero_o(zero_o), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  offset_gen_pipe #(.MUL_BW(12), .ACC_BW(32), .LANES(1)) dut12 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode12), .in_valid(inValid12), .in_ready(inReady12),
    .x_i(x12), .out_valid(outValid12), .out_ready(outReady12), .offset_o(offset12),
    .zero_o(zero12), .cfg_we(cfgWe12), .cfg_addr(cfgAddr12), .cfg_data(cfgData12)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog");
  end

  // Expected {zero, offset} for one beat, computed from the operand values.
  function automatic logic [131:0] model_beat(input logic [1:0] m, input logic [63:0] x);
    logic [127:0] off;
    logic [3:0]   z;
    int           v;
    int           p;
    off = '0;
    z   = '0;
    for (int k = 0; k < 4; k++) begin
      if (m == 2'b11) begin
        v = int'(x[k*16 +: 16]);
        if (v == 0) begin
          off[k*32 +: 32] = 32'h8000_0000;
          z[k]            = 1'b1;
        end else begin
          p = 0;
          while (v > 1) begin
            v = v / 2;
            p++;
          end
          off[k*32 +: 32] = mdlTable[p];
        end
      end
    end
    return {z, off};
  endfunction

  function automatic logic [63:0] rand_x();
    logic [63:0] x;
    x = '0;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 3))
        0:       x[k*16 +: 16] = 16'h0000;
        1:       x[k*16 +: 16] = 16'(1 << $urandom_range(0, 15));
        default: x[k*16 +: 16] = 16'($urandom);
      endcase
    end
    return x;
  endfunction

  // One cycle of stimulus: drive on the falling edge, let outputs settle, return before the rising edge.
  task automatic drive(input logic iv, input logic [1:0] m, input logic [63:0] x, input logic ordy,
                       input logic we, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    in_valid  = iv;
    mode_i    = m;
    x_i       = x;
    out_ready = ordy;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_data  = d;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; mode_i = '0; x_i = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    inValid12 = 1'b0; mode12 = '0; x12 = '0; outReady12 = 1'b0;
    cfgWe12 = 1'b0; cfgAddr12 = '0; cfgData12 = '0;
    for (int i = 0; i < 16; i++) mdlTable[i] = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || offset_o !== '0 || zero_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: out_valid=%b zero=%b offset=%h, required 0/0/0", out_valid, zero_o, offset_o);
    end
    rst_n = 1'b1;
    drive(1'b0, 2'b00, '0, 1'b1, 1'b0, '0, '0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_log_lookup();
    int lat;
    logic [127:0] gotOff;
    logic [3:0]   gotZ;
    drive(1'b0, 2'b00, '0, 1'b1, 1'b1, 4'd10, 32'h0000_1C00);
    mdlTable[10] = 32'h0000_1C00;
    drive(1'b0, 2'b00, '0, 1'b1, 1'b1, 4'd0, 32'h0000_1000);
    mdlTable[0] = 32'h0000_1000;
    drive(1'b1, 2'b11, {16'h0000, 16'h07FF, 16'h0001, 16'h0400}, 1'b1, 1'b0, '0, '0);
    lat = -1; gotOff = '0; gotZ = '0;
    for (int t = 1; t <= 5; t++) begin
      drive(1'b0, 2'b00, '0, 1'b1, 1'b0, '0, '0);
      if (out_valid === 1'b1 && lat < 0) begin
        lat = t; gotOff = offset_o; gotZ = zero_o;
      end
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("[TB] FAIL log_latency: got %0d cycles, required 2", lat);
    end
    checks++;
    if (gotOff !== {32'h8000_0000, 32'h0000_1C00, 32'h0000_1000, 32'h0000_1C00} || gotZ !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL log_lookup: offset=%h zero=%b, required 80000000_00001c00_00001000_00001c00 / 1000", gotOff, gotZ);
    end
  endtask

  task automatic test_non_log();
    int lat;
    logic [127:0] gotOff;
    logic [3:0]   gotZ;
    for (int m = 0; m < 3; m++) begin
      drive(1'b1, 2'(m), {16'h0000, 16'h07FF, 16'h0001, 16'h0400}, 1'b1, 1'b0, '0, '0);
      lat = -1; gotOff = '1; gotZ = '1;
      for (int t = 1; t <= 5; t++) begin
        drive(1'b0, 2'b00, '0, 1'b1, 1'b0, '0, '0);
        if (out_valid === 1'b1 && lat < 0) begin
          lat = t; gotOff = offset_o; gotZ = zero_o;
        end
      end
      checks++;
      if (lat !== 2 || gotOff !== '0 || gotZ !== '0) begin
        errors++;
        $display("[TB] FAIL non_log_mode%0d: latency=%0d offset=%h zero=%b, required 2/0/0", m, lat, gotOff, gotZ);
      end
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [31:0] got;
    logic [11:0] xs [2];
    logic [31:0] want [2];
    logic [3:0]  addrs [5];
    logic [31:0] datas [5];
    addrs[0] = 4'd11; datas[0] = 32'hAAAA_0001;
    addrs[1] = 4'd0;  datas[1] = 32'h0000_1234;
    addrs[2] = 4'd13; datas[2] = 32'hDEAD_0013;
    addrs[3] = 4'd12; datas[3] = 32'hBEEF_0012;
    addrs[4] = 4'd15; datas[4] = 32'hCAFE_0015;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfgWe12 = 1'b1; cfgAddr12 = addrs[i]; cfgData12 = datas[i]; outReady12 = 1'b1;
    end
    @(negedge clk);
    cfgWe12 = 1'b0;
    xs[0] = 12'h800; want[0] = 32'hAAAA_0001;
    xs[1] = 12'h001; want[1] = 32'h0000_1234;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      inValid12 = 1'b1; mode12 = 2'b11; x12 = xs[b];
      lat = -1; got = '0;
      for (int t = 1; t <= 5; t++) begin
        @(negedge clk);
        inValid12 = 1'b0;
        #1;
        if (outValid12 === 1'b1 && lat < 0) begin
          lat = t; got = offset12;
        end
      end
      checks++;
      if (lat !== 2 || got !== want[b]) begin
        errors++;
        $display("[TB] FAIL out_of_range_b%0d: latency=%0d offset=%h, required 2/%h", b, lat, got, want[b]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0]  beats [5];
    logic [131:0] e;
    logic         ordy;
    logic         prevStall;
    logic [127:0] prevOff;
    logic [3:0]   prevZ;
    int           sent;
    int           got;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 2'b00, '0, 1'b1, 1'b1, 4'(i), 32'h0001_0000 * (i + 1) + 32'(i));
      mdlTable[i] = 32'h0001_0000 * (i + 1) + 32'(i);
    end
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) beats[b][k*16 +: 16] = 16'($urandom_range(1, 16'hFFFF));
    end
    sent = 0; got = 0; prevStall = 1'b0; prevOff = '0; prevZ = '0;
    for (int t = 0; t < 30 && got < 5; t++) begin
      ordy = !(t >= 2 && t <= 4);
      drive(sent < 5, 2'b11, (sent < 5) ? beats[sent] : 64'h0, ordy, 1'b0, '0, '0);
      if (prevStall) begin
        checks++;
        if (out_valid !== 1'b1 || offset_o !== prevOff || zero_o !== prevZ) begin
          errors++;
          $display("[TB] FAIL bp_hold_t%0d: out_valid=%b offset=%h, required 1/%h", t, out_valid, offset_o, prevOff);
        end
      end
      if (t >= 2 && t <= 4) begin
        checks++;
        if (in_ready !== 1'b0 || expQ.size() != 2) begin
          errors++;
          $display("[TB] FAIL bp_in_ready_t%0d: in_ready=%b buffered=%0d, required 0/2", t, in_ready, expQ.size());
        end
      end
      if (out_valid === 1'b1 && ordy) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL bp_spurious: beat %h with nothing outstanding, required none", offset_o);
        end else begin
          e = expQ.pop_front();
          if ({zero_o, offset_o} !== e) begin
            errors++;
            $display("[TB] FAIL bp_beat%0d: got %h, required %h", got, {zero_o, offset_o}, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        expQ.push_back(model_beat(2'b11, beats[sent]));
        sent++;
      end
      prevStall = (out_valid === 1'b1) && !ordy;
      prevOff   = offset_o;
      prevZ     = zero_o;
    end
    checks++;
    if (got != 5 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_count: emitted %0d left %0d, required 5/0", got, expQ.size());
    end
    expQ.delete();
    repeat (2) drive(1'b0, 2'b00, '0, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic test_write_collision();
    logic [31:0] gotLane0 [2];
    int          n;
    drive(1'b0, 2'b00, '0, 1'b1, 1'b1, 4'd10, 32'h0000_1C00);
    drive(1'b1, 2'b11, {48'h0, 16'h0400}, 1'b1, 1'b0, '0, '0);
    drive(1'b1, 2'b11, {48'h0, 16'h0500}, 1'b1, 1'b1, 4'd10, 32'h0000_0055);
    mdlTable[10] = 32'h0000_0055;
    n = 0; gotLane0[0] = '0; gotLane0[1] = '0;
    for (int t = 0; t < 6; t++) begin
      drive(1'b0, 2'b00, '0, 1'b1, 1'b0, '0, '0);
      if (out_valid === 1'b1 && n < 2) begin
        gotLane0[n] = offset_o[31:0];
        n++;
      end
    end
    checks++;
    if (n != 2 || gotLane0[0] !== 32'h0000_1C00) begin
      errors++;
      $display("[TB] FAIL collision_old: beats=%0d lane0=%h, required 2/00001c00", n, gotLane0[0]);
    end
    checks++;
    if (gotLane0[1] !== 32'h0000_0055) begin
      errors++;
      $display("[TB] FAIL collision_new: lane0=%h, required 00000055", gotLane0[1]);
    end
  endtask

  task automatic test_random();
    logic [131:0] e;
    logic [63:0]  x;
    logic [1:0]   m;
    logic         iv;
    logic         ordy;
    logic         prevStall;
    logic [127:0] prevOff;
    logic [3:0]   prevZ;
    for (int i = 0; i < 16; i++) begin
      e[31:0] = $urandom;
      drive(1'b0, 2'b00, '0, 1'b1, 1'b1, 4'(i), e[31:0]);
      mdlTable[i] = e[31:0];
    end
    prevStall = 1'b0; prevOff = '0; prevZ = '0;
    for (int t = 0; t < 340; t++) begin
      iv   = (t < 300) && ($urandom_range(0, 9) < 7);
      ordy = (t >= 300) || ($urandom_range(0, 9) < 7);
      m    = $urandom_range(0, 1) ? 2'b11 : 2'($urandom_range(0, 3));
      x    = rand_x();
      drive(iv, m, x, ordy, 1'b0, '0, '0);
      if (prevStall) begin
        checks++;
        if (out_valid !== 1'b1 || offset_o !== prevOff || zero_o !== prevZ) begin
          errors++;
          $display("[TB] FAIL rand_hold_t%0d: out_valid=%b offset=%h, required 1/%h", t, out_valid, offset_o, prevOff);
        end
      end
      if (out_valid === 1'b1 && ordy) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_spurious_t%0d: beat %h with nothing outstanding, required none", t, offset_o);
        end else begin
          e = expQ.pop_front();
          if ({zero_o, offset_o} !== e) begin
            errors++;
            $display("[TB] FAIL rand_beat_t%0d: got %h, required %h", t, {zero_o, offset_o}, e);
          end
        end
      end
      if (iv && in_ready === 1'b1) expQ.push_back(model_beat(m, x));
      prevStall = (out_valid === 1'b1) && !ordy;
      prevOff   = offset_o;
      prevZ     = zero_o;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_drain: %0d beats never emerged, required 0", expQ.size());
    end
    expQ.delete();
  endtask

  task automatic test_reset_mid_stream();
    int seen;
    logic [127:0] gotOff;
    logic [3:0]   gotZ;
    drive(1'b0, 2'b00, '0, 1'b1, 1'b1, 4'd5, 32'h0000_0ABC);
    for (int t = 0; t < 3; t++) drive(1'b1, 2'b11, {48'h0, 16'h0020}, 1'b0, 1'b0, '0, '0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_fill: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || offset_o !== '0 || zero_o !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: out_valid=%b zero=%b offset=%h, required 0/0/0", out_valid, zero_o, offset_o);
    end
    for (int i = 0; i < 16; i++) mdlTable[i] = '0;
    drive(1'b0, 2'b00, '0, 1'b1, 1'b0, '0, '0);
    rst_n = 1'b1;
    seen = 0;
    for (int t = 0; t < 4; t++) begin
      drive(1'b0, 2'b00, '0, 1'b1, 1'b0, '0, '0);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL mid_flush: %0d cycles with stale beat or in_ready low, required 0", seen);
    end
    drive(1'b1, 2'b11, {16'h8000, 16'h0100, 16'h0003, 16'h0020}, 1'b1, 1'b0, '0, '0);
    seen = 0; gotOff = '1; gotZ = '1;
    for (int t = 0; t < 5; t++) begin
      drive(1'b0, 2'b00, '0, 1'b1, 1'b0, '0, '0);
      if (out_valid === 1'b1 && seen == 0) begin
        seen = 1; gotOff = offset_o; gotZ = zero_o;
      end
    end
    checks++;
    if (seen != 1 || gotOff !== '0 || gotZ !== '0) begin
      errors++;
      $display("[TB] FAIL mid_table_cleared: beats=%0d offset=%h zero=%b, required 1/0/0", seen, gotOff, gotZ);
    end
  endtask

  initial begin
    test_reset();
    test_log_lookup();
    test_non_log();
    test_out_of_range();
    test_backpressure();
    test_write_collision();
    test_random();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
